// File: rtl/if_fetch.sv
// Instruction fetch: holds the PC, fetches words over imem req/ack and queues them (2 entries) for decode.
// Latency: a request issues one cycle after the queue has room, and the returned word is at ins one cycle after ack.
// Backpressure: a full queue stops further requests, and ins_ready=0 holds the head. `IF_DELAY_SLOT_EN keeps one delay-slot instruction on redirect.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        clr_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    localparam logic [1:0] QD = DEPTH[1:0];

    state_t      state_q, state_n;
    logic        req_n;
    logic [31:0] addr_n;
    logic [31:0] fetch_pc, fpc_n;
    logic        ds_hold, hold_n;
    logic        rd_ptr, rd_n;
    logic [1:0]  cnt, cn, cnt_n;
    logic        push, wr_idx, pop, ack_v;
    logic        keep_q, keep_bus;
    logic [31:0] target;
    logic [31:0] q_ins [2];
    logic [31:0] q_pc  [2];

    assign ins_valid = (cnt != 2'd0);
    assign ins       = q_ins[rd_ptr];
    assign ins_pc    = q_pc[rd_ptr];
    assign pop       = ins_valid & ins_ready;
    assign ack_v     = imem_req & imem_ack;
    assign target    = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_n  = state_q;
        req_n    = imem_req;
        addr_n   = imem_addr;
        fpc_n    = fetch_pc;
        hold_n   = ds_hold;
        rd_n     = rd_ptr ^ pop;
        cn       = cnt - {1'b0, pop};
        push     = 1'b0;
        keep_q   = 1'b0;
        keep_bus = 1'b0;

        case (state_q)
            IDLE: begin
                if (cnt < QD) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ack_v) begin
                    push    = 1'b1;
                    // A delay-slot fetch returns after fetch_pc was already retargeted.
                    if (!ds_hold)
                        fpc_n = fetch_pc + 32'd4;
                    hold_n  = 1'b0;
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (ack_v) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef IF_DELAY_SLOT_EN
        keep_q   = (cn != 2'd0);
        keep_bus = !keep_q && (state_q != DRAIN);
`endif

        if (redirect) begin
            fpc_n  = target;
            hold_n = 1'b0;
            push   = 1'b0;
            cn     = keep_q ? 2'd1 : 2'd0;
            if (keep_bus) begin
                if (state_q == IDLE) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    state_n = REQ;
                    hold_n  = 1'b1;
                end else if (ack_v) begin
                    push    = 1'b1;
                    req_n   = 1'b1;
                    addr_n  = target;
                    state_n = REQ;
                end else begin
                    req_n   = 1'b1;
                    addr_n  = imem_addr;
                    state_n = REQ;
                    hold_n  = 1'b1;
                end
            end else if (state_q == DRAIN || (state_q == REQ && !ack_v)) begin
                // The bus request cannot be retracted; its data is dropped on return.
                req_n   = 1'b1;
                addr_n  = imem_addr;
                state_n = DRAIN;
            end else begin
                req_n   = 1'b1;
                addr_n  = target;
                state_n = REQ;
            end
        end

        wr_idx = rd_n ^ cn[0];
        cnt_n  = cn + {1'b0, push};
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            ds_hold   <= 1'b0;
            rd_ptr    <= 1'b0;
            cnt       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_ins[i] <= 32'h0;
                q_pc[i]  <= RESET_PC;
            end
        end else begin
            imem_req  <= req_n;
            imem_addr <= addr_n;
            fetch_pc  <= fpc_n;
            ds_hold   <= hold_n;
            rd_ptr    <= rd_n;
            cnt       <= cnt_n;
            if (push) begin
                q_ins[wr_idx] <= imem_rdata;
                q_pc[wr_idx]  <= imem_addr;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: main instance at RESET_PC=0, second instance at RESET_PC=0xFFFF_FFF8.
module tb_if_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ins, ins_pc;
    logic        ins_valid, ins_ready;

    logic        u2_req, u2_valid;
    logic [31:0] u2_addr, u2_ins, u2_pc, u2_rdata;

    int          ack_dly;
    int          wait_cnt;
    int          total = 0;
    int          bad   = 0;

    assign imem_ack   = imem_req && (wait_cnt >= ack_dly);
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};
    assign u2_rdata   = {16'hC0DE, u2_addr[15:0]};

    if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .clr_n(clr_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .clr_n(clr_n),
        .imem_req(u2_req), .imem_addr(u2_addr),
        .imem_ack(u2_req), .imem_rdata(u2_rdata),
        .redirect(1'b0), .redirect_pc(32'h0),
        .ins(u2_ins), .ins_pc(u2_pc), .ins_valid(u2_valid), .ins_ready(1'b1)
    );

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            wait_cnt <= 0;
        else if (imem_req && !imem_ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    logic [31:0] got_pc[$], got_ins[$], acked[$], got2_pc[$], got2_ins[$];
    int          ack_cnt;

    always @(negedge clk) begin
        if (!clr_n) begin
            got_pc.delete(); got_ins.delete(); acked.delete();
            got2_pc.delete(); got2_ins.delete();
            ack_cnt = 0;
        end else begin
            if (ins_valid && ins_ready) begin
                got_pc.push_back(ins_pc);
                got_ins.push_back(ins);
            end
            if (imem_req && imem_ack) begin
                acked.push_back(imem_addr);
                ack_cnt++;
            end
            if (u2_valid) begin
                got2_pc.push_back(u2_pc);
                got2_ins.push_back(u2_ins);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        clr_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ins_ready   = 1'b0;
        ack_dly     = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (imem_req) break;
        end
        if (!imem_req) chk(tag, 32'(imem_req), 32'd1);
    endtask

    initial begin
        // reset values and plain streaming with ack tied high
        do_reset();
        @(negedge clk);
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_addr",  imem_addr,      32'h0);
        chk("rst_vld",   32'(ins_valid), 32'd0);
        chk("rst_ins",   ins,            32'h0);
        chk("rst_pc",    ins_pc,         32'h0);
        chk("rst_pc2",   u2_pc,          32'hFFFF_FFF8);
        ins_ready = 1'b1;
        release_rst();
        @(negedge clk);
        chk("t1_noreq_yet", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("t1_first_req",  32'(imem_req), 32'd1);
        chk("t1_first_addr", imem_addr,     32'h0);
        repeat (14) @(negedge clk);
        chk("t1_n", 32'(got_pc.size() >= 3), 32'd1);
        chk("t1_pc0",  got_pc[0],  32'h0);
        chk("t1_pc1",  got_pc[1],  32'h4);
        chk("t1_pc2",  got_pc[2],  32'h8);
        chk("t1_ins0", got_ins[0], 32'hC0DE_0000);
        chk("t1_ins1", got_ins[1], 32'hC0DE_0004);
        chk("t1_ins2", got_ins[2], 32'hC0DE_0008);
        // wrap-around instance ran alongside
        chk("t5_n", 32'(got2_pc.size() >= 3), 32'd1);
        chk("t5_pc0",  got2_pc[0],  32'hFFFF_FFF8);
        chk("t5_pc1",  got2_pc[1],  32'hFFFF_FFFC);
        chk("t5_pc2",  got2_pc[2],  32'h0000_0000);
        chk("t5_ins0", got2_ins[0], 32'hC0DE_FFF8);
        chk("t5_ins2", got2_ins[2], 32'hC0DE_0000);

        // stalled decode: queue fills after two acks
        do_reset();
        release_rst();
        repeat (16) @(negedge clk);
        chk("t2_acks",  32'(ack_cnt),   32'd2);
        chk("t2_req",   32'(imem_req),  32'd0);
        chk("t2_vld",   32'(ins_valid), 32'd1);
        chk("t2_ins",   ins,            32'hC0DE_0000);
        chk("t2_pc",    ins_pc,         32'h0);
        @(posedge clk);
        #1 ins_ready = 1'b1;
        wait_req("t2_resume_to", 10);
        chk("t2_resume_addr", imem_addr, 32'h8);

        // slow memory: request held stable for three wait cycles
        do_reset();
        ins_ready = 1'b1;
        ack_dly   = 3;
        release_rst();
        wait_req("t3_req_to", 10);
        begin
            int waits = 0;
            for (int k = 0; k < 10; k++) begin
                if (imem_ack) break;
                chk("t3_addr_stable", imem_addr, 32'h0);
                chk("t3_req_stable", 32'(imem_req), 32'd1);
                chk("t3_no_vld", 32'(ins_valid), 32'd0);
                waits++;
                @(negedge clk);
            end
            chk("t3_waits", 32'(waits), 32'd3);
        end
        @(negedge clk);
        chk("t3_vld", 32'(ins_valid), 32'd1);
        chk("t3_pc",  ins_pc,         32'h0);

        // redirect while the fetch of 0x8 is outstanding
        do_reset();
        ins_ready = 1'b1;
        ack_dly   = 3;
        release_rst();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) break;
        end
        chk("t4_req8", 32'(imem_req && imem_addr == 32'h8), 32'd1);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(posedge clk);
        #1 redirect = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_nacks", 32'(acked.size() >= 5), 32'd1);
        chk("t4_ack2",  acked[2], 32'h8);
        chk("t4_ack3",  acked[3], 32'h100);
        chk("t4_ack4",  acked[4], 32'h104);
        chk("t4_n", 32'(got_pc.size() >= 4), 32'd1);
        chk("t4_pc0",  got_pc[0],  32'h0);
        chk("t4_pc1",  got_pc[1],  32'h4);
        chk("t4_pc2",  got_pc[2],  32'h100);
        chk("t4_pc3",  got_pc[3],  32'h104);
        chk("t4_ins2", got_ins[2], 32'hC0DE_0100);

        // redirect with 0x4 and 0x8 queued
        do_reset();
        release_rst();
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 ins_ready = 1'b1;
        @(posedge clk);
        #1 ins_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_acks", 32'(ack_cnt), 32'd3);
        chk("t6_head", ins_pc,       32'h4);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        ins_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_n", 32'(got_pc.size() >= 3), 32'd1);
        chk("t6_pc0", got_pc[0], 32'h0);
`ifdef IF_DELAY_SLOT_EN
        chk("t6_pc1", got_pc[1], 32'h4);
        chk("t6_pc2", got_pc[2], 32'h40);
`else
        chk("t6_pc1", got_pc[1], 32'h40);
        chk("t6_pc2", got_pc[2], 32'h44);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
